// File: rtl/ps2_cmd_sequencer.sv
// PS/2 host-to-keyboard command sequencer: sends one or two command bytes,
// waits for the writer and the keyboard acknowledge, and resends on request.
//
// state       | meaning
// ------------+------------------------------------------------------
// IDLE        | ready for a command, cmd_ready high
// LOAD        | one-cycle tx_load of the current byte
// WAIT_START  | waiting for the writer to raise tx_busy
// WAIT_TX     | writer busy, waiting for tx_busy to fall
// WAIT_ACK    | waiting for FA/FE from the keyboard
// DONE        | one-cycle done pulse
// FAIL        | one-cycle error pulse, err_code valid
module ps2_cmd_sequencer #(
    parameter int TIMEOUT_CYC = 20000,
    parameter int MAX_RETRY   = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    input  logic [7:0] cmd_byte0,
    input  logic [7:0] cmd_byte1,
    input  logic       cmd_two,
    output logic       cmd_ready,
    output logic       done,
    output logic       error,
    output logic [1:0] err_code,
    output logic [7:0] tx_data,
    output logic       tx_load,
    input  logic       tx_busy,
    input  logic       tx_error,
    input  logic       rx_valid,
    input  logic [7:0] rx_byte,
    output logic       rx_enable
);

    localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
    localparam logic [15:0] TO_LAST = (TIMEOUT_CYC > 65536) ? 16'hFFFF :
                                      (TIMEOUT_CYC < 1)     ? 16'h0000 :
                                      16'(TIMEOUT_CYC - 1);

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_TIMEOUT = 2'b01;
    localparam logic [1:0] ERR_RESEND  = 2'b10;
    localparam logic [1:0] ERR_TX      = 2'b11;

    localparam logic [7:0] KB_ACK    = 8'hFA;
    localparam logic [7:0] KB_RESEND = 8'hFE;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WAIT_START,
        ST_WAIT_TX,
        ST_WAIT_ACK,
        ST_DONE,
        ST_FAIL
    } state_t;

    state_t          state;
    logic [15:0]     timer;
    logic [RW-1:0]   retry;
    logic            byte_idx;
    logic [7:0]      byte1_q;
    logic            two_q;
    logic            timed_out;

    assign timed_out = (timer >= TO_LAST);

    // Every state entry restarts the timer and sets the registered outputs
    // for the state being entered.
    task automatic go_to(input state_t nxt);
        state     <= nxt;
        timer     <= '0;
        cmd_ready <= (nxt == ST_IDLE);
        tx_load   <= (nxt == ST_LOAD);
        done      <= (nxt == ST_DONE);
        error     <= (nxt == ST_FAIL);
        rx_enable <= !((nxt == ST_LOAD) || (nxt == ST_WAIT_START) || (nxt == ST_WAIT_TX));
    endtask

    task automatic fail_with(input logic [1:0] code);
        err_code <= code;
        go_to(ST_FAIL);
    endtask

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            timer     <= '0;
            retry     <= '0;
            byte_idx  <= 1'b0;
            byte1_q   <= 8'h00;
            two_q     <= 1'b0;
            cmd_ready <= 1'b1;
            done      <= 1'b0;
            error     <= 1'b0;
            err_code  <= ERR_NONE;
            tx_data   <= 8'h00;
            tx_load   <= 1'b0;
            rx_enable <= 1'b1;
        end else begin
            timer <= (timer == 16'hFFFF) ? timer : timer + 16'd1;
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        byte1_q  <= cmd_byte1;
                        two_q    <= cmd_two;
                        byte_idx <= 1'b0;
                        retry    <= '0;
                        err_code <= ERR_NONE;
                        tx_data  <= cmd_byte0;
                        go_to(ST_LOAD);
                    end
                end
                ST_LOAD: go_to(ST_WAIT_START);
                ST_WAIT_START: begin
                    if (tx_busy) begin
                        go_to(ST_WAIT_TX);
                    end else if (timed_out) begin
                        fail_with(ERR_TIMEOUT);
                    end
                end
                ST_WAIT_TX: begin
                    // entered with tx_busy high, so a low sample is the falling edge
                    if (!tx_busy) begin
                        if (!tx_error) begin
                            go_to(ST_WAIT_ACK);
                        end else if (retry < RETRY_MAX) begin
                            retry <= retry + 1'b1;
                            go_to(ST_LOAD);
                        end else begin
                            fail_with(ERR_TX);
                        end
                    end else if (timed_out) begin
                        fail_with(ERR_TIMEOUT);
                    end
                end
                ST_WAIT_ACK: begin
                    if (rx_valid && (rx_byte == KB_ACK)) begin
                        if (two_q && !byte_idx) begin
                            byte_idx <= 1'b1;
                            retry    <= '0;
                            tx_data  <= byte1_q;
                            go_to(ST_LOAD);
                        end else begin
                            go_to(ST_DONE);
                        end
                    end else if (rx_valid && (rx_byte == KB_RESEND)) begin
                        if (retry < RETRY_MAX) begin
                            retry <= retry + 1'b1;
                            go_to(ST_LOAD);
                        end else begin
                            fail_with(ERR_RESEND);
                        end
                    end else if (timed_out) begin
                        fail_with(ERR_TIMEOUT);
                    end
                end
                ST_DONE: go_to(ST_IDLE);
                ST_FAIL: go_to(ST_IDLE);
                default: go_to(ST_IDLE);
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_cmd_sequencer.sv
// Self-checking bench for ps2_cmd_sequencer: a writer/keyboard responder follows
// a per-transmission plan and a plan-walking model predicts the outcome.
module tb_ps2_cmd_sequencer;

    localparam int TO       = 40;
    localparam int MR       = 3;
    localparam int PLAN_MAX = 16;
    localparam int BOUND    = 4 * TO + 100;

    localparam int K_ACK     = 0;
    localparam int K_NAK     = 1;
    localparam int K_TXERR   = 2;
    localparam int K_JUNK    = 3;
    localparam int K_NOBUSY  = 4;
    localparam int K_NOREPLY = 5;
    localparam int K_STUCK   = 6;
    localparam int K_COINC   = 7;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [7:0] cmd_byte0 = 8'h00;
    logic [7:0] cmd_byte1 = 8'h00;
    logic       cmd_two = 1'b0;
    logic       cmd_ready;
    logic       done;
    logic       error;
    logic [1:0] err_code;
    logic [7:0] tx_data;
    logic       tx_load;
    logic       tx_busy = 1'b0;
    logic       tx_error = 1'b0;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_byte = 8'h00;
    logic       rx_enable;

    ps2_cmd_sequencer #(.TIMEOUT_CYC(TO), .MAX_RETRY(MR)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_byte0(cmd_byte0), .cmd_byte1(cmd_byte1), .cmd_two(cmd_two),
        .cmd_ready(cmd_ready), .done(done), .error(error), .err_code(err_code),
        .tx_data(tx_data), .tx_load(tx_load), .tx_busy(tx_busy), .tx_error(tx_error),
        .rx_valid(rx_valid), .rx_byte(rx_byte), .rx_enable(rx_enable)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int load_cnt = 0, done_cnt = 0, err_cnt = 0;
    int cyc = 0, load_cyc = 0, err_cyc = 0;
    int fixed_busy = 0;
    int plan [PLAN_MAX];
    logic [7:0] got_q [$];
    logic [7:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Monitor: records every load strobe and pulse; while loading the
    // receiver must be disabled and the sequencer must not be ready.
    always @(negedge clk) begin
        cyc++;
        if (tx_load === 1'b1) begin
            got_q.push_back(tx_data);
            load_cnt++;
            load_cyc = cyc;
            check("load_flags", {30'd0, rx_enable, cmd_ready}, 32'd0);
        end
        if (done === 1'b1) done_cnt++;
        if (error === 1'b1) begin
            err_cnt++;
            err_cyc = cyc;
        end
    end

    task automatic set_plan(input int p0, input int p1, input int p2, input int p3);
        for (int i = 0; i < PLAN_MAX; i++) plan[i] = K_ACK;
        plan[0] = p0; plan[1] = p1; plan[2] = p2; plan[3] = p3;
    endtask

    // Reference: walk the plan using the command rules (ack advances byte or
    // finishes, resend/tx error consume retries, silence is a timeout).
    task automatic model(input logic [7:0] b0, input logic [7:0] b1, input bit two,
                         output int n, output bit ok, output logic [1:0] code, output int last_kind);
        int idx;
        int retry;
        idx = 0; retry = 0; n = 0; ok = 1'b0; code = 2'b00; last_kind = K_ACK;
        exp_q.delete();
        for (int k = 0; k < PLAN_MAX; k++) begin
            exp_q.push_back(idx != 0 ? b1 : b0);
            n++;
            last_kind = plan[k];
            case (plan[k])
                K_ACK, K_JUNK, K_COINC: begin
                    if (two && idx == 0) begin idx = 1; retry = 0; end
                    else begin ok = 1'b1; return; end
                end
                K_NAK: begin
                    if (retry < MR) retry++;
                    else begin code = 2'b10; return; end
                end
                K_TXERR: begin
                    if (retry < MR) retry++;
                    else begin code = 2'b11; return; end
                end
                default: begin code = 2'b01; return; end
            endcase
        end
    endtask

    task automatic wait_fin(input int base);
        int w;
        w = 0;
        while ((done_cnt + err_cnt) == base && w < BOUND) begin
            @(negedge clk);
            w++;
        end
    endtask

    // Acts as writer and keyboard for one transmission; returns on a negedge.
    task automatic respond(input int kind, input int fin_base);
        int d, n, a;
        d = $urandom_range(1, 3);
        n = (fixed_busy > 0) ? fixed_busy : $urandom_range(1, 8);
        repeat (d) @(negedge clk);
        if (kind == K_NOBUSY) return;
        tx_busy = 1'b1;
        if (kind == K_STUCK) begin
            wait_fin(fin_base);
            tx_busy = 1'b0;
            return;
        end
        for (int i = 0; i < n; i++) begin
            if (i == 1) begin
                rx_valid = 1'b1; rx_byte = 8'hFA;
                cmd_valid = 1'b1; cmd_byte0 = 8'($urandom);
            end
            if (i == 2) begin rx_valid = 1'b0; cmd_valid = 1'b0; end
            @(negedge clk);
        end
        rx_valid = 1'b0; cmd_valid = 1'b0;
        tx_busy = 1'b0;
        tx_error = (kind == K_TXERR);
        @(negedge clk);
        tx_error = 1'b0;
        if (kind == K_TXERR || kind == K_NOREPLY) return;
        if (kind == K_JUNK) begin
            rx_valid = 1'b1; rx_byte = 8'h1C;
            @(negedge clk);
            rx_valid = 1'b0;
            @(negedge clk);
        end else begin
            a = (kind == K_COINC) ? TO : $urandom_range(1, 5);
            repeat (a - 1) @(negedge clk);
        end
        rx_valid = 1'b1;
        rx_byte = (kind == K_NAK) ? 8'hFE : 8'hFA;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic run_cmd(input string name, input logic [7:0] b0, input logic [7:0] b1, input bit two);
        int exp_n, last_kind, base_load, base_done, base_err, fin_base, k, w, m;
        bit ok, timed;
        logic [1:0] code;
        model(b0, b1, two, exp_n, ok, code, last_kind);
        base_load = load_cnt; base_done = done_cnt; base_err = err_cnt;
        fin_base = done_cnt + err_cnt;
        got_q.delete();
        cmd_byte0 = b0; cmd_byte1 = b1; cmd_two = two; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0; cmd_byte0 = 8'($urandom); cmd_byte1 = 8'($urandom);
        k = 0; timed = 1'b0;
        while (1) begin
            w = 0;
            while (tx_load !== 1'b1 && (done_cnt + err_cnt) == fin_base && w < BOUND) begin
                @(negedge clk);
                w++;
            end
            if (w >= BOUND) begin timed = 1'b1; break; end
            if ((done_cnt + err_cnt) != fin_base) break;
            respond((k < PLAN_MAX) ? plan[k] : K_ACK, fin_base);
            k++;
        end
        repeat (4) @(negedge clk);
        check({name, ":wait_bound"}, 32'(timed), 32'd0);
        check({name, ":load_count"}, 32'(load_cnt - base_load), 32'(exp_n));
        m = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < m; i++) check({name, ":load_byte"}, 32'(got_q[i]), 32'(exp_q[i]));
        check({name, ":done_pulses"}, 32'(done_cnt - base_done), 32'(ok));
        check({name, ":error_pulses"}, 32'(err_cnt - base_err), 32'(!ok));
        check({name, ":err_code"}, 32'(err_code), 32'(code));
        check({name, ":idle_flags"}, {30'd0, cmd_ready, rx_enable}, 32'd3);
        if (!ok && last_kind == K_NOBUSY)
            check({name, ":start_timeout_cycles"}, 32'(err_cyc - load_cyc), 32'(TO + 1));
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int base_load, base_done, base_err, w;
        int r;
        logic [7:0] rb0, rb1;

        repeat (3) @(negedge clk);
        check("reset_ready_rxen", {30'd0, cmd_ready, rx_enable}, 32'd3);
        check("reset_pulses", {29'd0, done, error, tx_load}, 32'd0);
        check("reset_err_code", 32'(err_code), 32'd0);
        check("reset_tx_data", 32'(tx_data), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        fixed_busy = 10;
        set_plan(K_ACK, K_ACK, K_ACK, K_ACK);         run_cmd("ed02", 8'hED, 8'h02, 1'b1);
        fixed_busy = 0;
        set_plan(K_NAK, K_NAK, K_ACK, K_ACK);         run_cmd("ff_nak2", 8'hFF, 8'h00, 1'b0);
        set_plan(K_NAK, K_NAK, K_NAK, K_NAK);         run_cmd("ff_nak4", 8'hFF, 8'h00, 1'b0);
        set_plan(K_NOBUSY, K_ACK, K_ACK, K_ACK);      run_cmd("f4_nobusy", 8'hF4, 8'h00, 1'b0);
        set_plan(K_TXERR, K_TXERR, K_TXERR, K_TXERR); run_cmd("ee_txerr", 8'hEE, 8'h00, 1'b0);
        set_plan(K_JUNK, K_ACK, K_ACK, K_ACK);        run_cmd("junk_ack", 8'hF2, 8'h00, 1'b0);
        set_plan(K_COINC, K_ACK, K_ACK, K_ACK);       run_cmd("ack_at_timeout", 8'hF5, 8'h00, 1'b0);
        set_plan(K_ACK, K_NOREPLY, K_ACK, K_ACK);     run_cmd("no_reply", 8'hF3, 8'h20, 1'b1);
        set_plan(K_STUCK, K_ACK, K_ACK, K_ACK);       run_cmd("busy_stuck", 8'hF0, 8'h00, 1'b0);
        set_plan(K_NAK, K_ACK, K_TXERR, K_ACK);       run_cmd("two_mixed", 8'hED, 8'h07, 1'b1);

        // Reset while the writer is busy.
        base_load = load_cnt; base_done = done_cnt; base_err = err_cnt;
        cmd_byte0 = 8'hF6; cmd_two = 1'b0; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        w = 0;
        while (tx_load !== 1'b1 && w < BOUND) begin @(negedge clk); w++; end
        check("rst_mid:load_seen", 32'(tx_load), 32'd1);
        @(negedge clk);
        tx_busy = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_mid:ready_rxen", {30'd0, cmd_ready, rx_enable}, 32'd3);
        check("rst_mid:pulses", {29'd0, done, error, tx_load}, 32'd0);
        check("rst_mid:tx_data", 32'(tx_data), 32'd0);
        tx_busy = 1'b0; tx_error = 1'b1;
        repeat (3) @(negedge clk);
        tx_error = 1'b0; rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("rst_mid:no_pulse", 32'((done_cnt - base_done) + (err_cnt - base_err)), 32'd0);
        check("rst_mid:loads", 32'(load_cnt - base_load), 32'd1);

        for (int c = 0; c < 40; c++) begin
            for (int i = 0; i < PLAN_MAX; i++) begin
                r = $urandom_range(0, 99);
                plan[i] = (r < 40) ? K_ACK : (r < 60) ? K_NAK : (r < 75) ? K_TXERR :
                          (r < 85) ? K_JUNK : (r < 90) ? K_NOBUSY : (r < 95) ? K_NOREPLY :
                          (r < 98) ? K_STUCK : K_COINC;
            end
            rb0 = 8'($urandom); rb1 = 8'($urandom);
            run_cmd("random", rb0, rb1, 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
